// File: rtl/pe_relay_ne.sv
// pe_relay_ne: north/east relay tile; east words turn north, north words turn east, each through a credit-safe FIFO.
// Optional macro PE_RELAY_DEEP_FIFO_EN selects 4-entry FIFOs per path (default 2).

module pe_relay_ne_path #(
   parameter int W     = 130,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         run,
   input  logic         in_valid,
   input  logic [W-3:0] in_payload,
   input  logic         dn_ready,
   output logic         out_valid,
   output logic         up_ready,
   output logic [W-3:0] out_payload
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-3:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count, count_next;
   logic          pop, push;

   function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A simultaneous pop frees the slot, so a push into a full FIFO is accepted then.
   always_comb begin
      pop        = run && (count != '0) && dn_ready;
      push       = in_valid && ((count != CW'(DEPTH)) || pop);
      count_next = count;
      if (push && !pop)
         count_next = count + 1'b1;
      else if (pop && !push)
         count_next = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         up_ready    <= 1'b0;
         out_valid   <= 1'b0;
         out_payload <= '0;
      end else begin
         count     <= count_next;
         up_ready  <= (count_next < CW'(DEPTH));
         out_valid <= pop;
         if (pop) begin
            out_payload <= mem[rd_ptr];
            rd_ptr      <= inc_ptr(rd_ptr);
         end
         if (push)
            wr_ptr <= inc_ptr(wr_ptr);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_payload;
   end
endmodule

module pe_relay_ne #(
   parameter int EAST_WIDTH         = 130,
   parameter int NORTH_WIDTH        = 130,
   parameter int NUM_BRAM_ADDR_BITS = 7,
   parameter int DUMMY_WIDTH        = 130
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ap_start,
   input  logic [EAST_WIDTH-1:0]  in_from_east,
   input  logic [NORTH_WIDTH-1:0] in_from_north,
   output logic [EAST_WIDTH-1:0]  out_to_east,
   output logic [NORTH_WIDTH-1:0] out_to_north
);
`ifdef PE_RELAY_DEEP_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 2;
`endif
   localparam int W = EAST_WIDTH;

   if (EAST_WIDTH != NORTH_WIDTH || NUM_BRAM_ADDR_BITS < 0 || DUMMY_WIDTH < 0) begin : g_bad_cfg
      $error("pe_relay_ne: EAST_WIDTH must equal NORTH_WIDTH");
   end

   // Path 0 = east->north, path 1 = north->east.
   logic [1:0]          in_vld, dn_rdy, out_vld, up_rdy;
   logic [1:0][W-3:0]   in_pay, out_pay;
   logic                run;

   always_ff @(posedge clk) begin
      if (reset)
         run <= 1'b0;
      else if (ap_start)
         run <= 1'b1;
   end

   assign in_vld = {in_from_north[W-1], in_from_east[W-1]};
   assign dn_rdy = {in_from_east[W-2], in_from_north[W-2]};
   assign in_pay = {in_from_north[W-3:0], in_from_east[W-3:0]};

   for (genvar i = 0; i < 2; i++) begin : g_path
      pe_relay_ne_path #(.W(W), .DEPTH(DEPTH)) u_path (
         .clk        (clk),
         .reset      (reset),
         .run        (run),
         .in_valid   (in_vld[i]),
         .in_payload (in_pay[i]),
         .dn_ready   (dn_rdy[i]),
         .out_valid  (out_vld[i]),
         .up_ready   (up_rdy[i]),
         .out_payload(out_pay[i])
      );
   end

   // Each outgoing link carries its path's word plus the ready for the opposite path's input.
   assign out_to_north = {out_vld[0], up_rdy[1], out_pay[0]};
   assign out_to_east  = {out_vld[1], up_rdy[0], out_pay[1]};
endmodule
